md_unit_param: RTL and testbench
================================

Name: md_unit_param

Overview:
- Parametrised multiply/divide unit for the pipelined MIPS core; successor to the fixed 32-bit HI/LO unit.
- Sits in the EX stage. Takes operands from the forwarded rs/rt values.
- Holds the HI/LO registers and reports busy/start to the hazard unit, which stalls any later MD-class instruction.
- New over the previous unit: width and latencies are parameters; adds madd/maddu/msub/msubu, a divide-by-zero flag, defined overflow results and a cancel input for exception flush.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be >= 2.
- MULT_LAT, 5, busy cycles for mult/multu/madd/maddu/msub/msubu; must be >= 1.
- DIV_LAT, 10, busy cycles for div/divu; must be >= 1.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  EX-stage instruction is valid and not stalled.
- op  in  4  0 nop, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 maddu, 7 msub, 8 msubu, 9 mthi, 10 mtlo, 11-15 nop.
- rs_val  in  WIDTH  operand A; also the data source for mthi/mtlo.
- rt_val  in  WIDTH  operand B (multiplier or divisor).
- cancel  in  1  flush: abort the in-flight operation and drop the current issue.
- start  out  1  combinational; op_valid && op in 1..8.
- busy  out  1  operation in flight.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- div_zero  out  1  one-cycle pulse when a div/divu with zero divisor completes.

Behaviour:
- Reset (async, any time including mid-operation): hi=0, lo=0, busy=0, div_zero=0. Internal counter, latched op and latched operands are cleared.
- Accept: idle (busy=0), start=1, cancel=0.
  - Next edge latches op, rs_val and rt_val.
  - Counter loads LAT (MULT_LAT or DIV_LAT by op); busy=1.
- Run: each edge with busy=1 decrements the counter.
- Complete: on the edge where counter==1.
  - hi/lo are written and busy=0.
  - busy is therefore high for exactly LAT cycles; the result is visible the cycle busy falls.
  - A new op may be accepted on the cycle after completion; back-to-back issue needs no gap beyond busy.
- Issue while busy: ignored; the hazard unit stalls it and it re-presents.
- mthi/mtlo while idle and cancel=0: next edge writes rs_val into hi (or lo); the other register is unchanged; busy stays 0.
- mthi/mtlo while busy: ignored.
- Results: P is the 2*WIDTH product {hi,lo}.
  - mult: signed product. multu: unsigned product.
  - madd/maddu: {hi,lo} + P, signed or unsigned product respectively.
  - msub/msubu: {hi,lo} - P.
  - All accumulate arithmetic wraps modulo 2^(2*WIDTH).
- Division:
  - div: signed; quotient to lo, truncated toward zero; remainder to hi, taking the sign of the dividend.
  - divu: unsigned.
  - Signed most-negative / -1 gives lo = most-negative, hi = 0.
- Divide by zero: hi/lo unchanged; div_zero=1 for exactly the completion cycle; busy timing is the same as a normal divide.
- cancel=1:
  - Next edge clears busy and the counter; hi/lo are not written; no div_zero.
  - cancel takes priority over completion on the same edge.
  - cancel in the same cycle as an issue or mthi/mtlo drops that op.
  - start still reflects op combinationally.
- div_zero is 0 in all cycles other than a zero-divisor completion.

Test Plan:
- mult rs=0xFFFFFFFD (-3), rt=5 at WIDTH=32 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy=0.
- div rs=0x80000000, rt=0xFFFFFFFF -> after 10 cycles lo=0x80000000, hi=0. Then div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- mthi 0, mtlo 0xFFFFFFFF, then maddu 1*1 -> hi=1, lo=0. Then msub 2*3 -> {hi,lo}=0x00000000_FFFFFFFA.
- divu 7/0 with hi=0x11, lo=0x22 -> div_zero pulses once at cycle 10; hi/lo stay 0x11/0x22.
- Start div; mtlo at cycle 3 (ignored); cancel at cycle 6 -> busy drops next edge, hi/lo unchanged. Then mult 2*3 is accepted immediately -> lo=6.
- reset asserted mid-mult (between clock edges) -> hi, lo, busy and div_zero are 0 immediately, with no clock edge. Repeat mult 4*4 at WIDTH=16, MULT_LAT=1 -> busy 1 cycle, lo=0x0010.

Source files
------------

// File: rtl/md_unit_param.sv
// HI/LO multiply/divide unit for the EX stage: one operation in flight, fixed
// per-class latency, with accumulate, divide-by-zero flag and flush cancel.
module md_unit_param #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             cancel,
  output logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;

  logic             mul_signed;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, mul_res;
  logic             is_div, div_signed, a_neg, b_neg, b_is_zero;
  logic [WIDTH-1:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  assign start = op_valid && (op >= OP_MULT) && (op <= OP_MSUBU);

  // Products are formed at full 2*WIDTH on sign- or zero-extended operands, so
  // the low 2*WIDTH bits are the correctly signed product.
  always_comb begin
    mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    ext_a = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod  = ext_a * ext_b;
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = {hi, lo} + prod;
      OP_MSUB, OP_MSUBU: mul_res = {hi, lo} - prod;
      default:           mul_res = prod;
    endcase
  end

  // Signed divide on magnitudes; most-negative / -1 falls out naturally as
  // quotient most-negative, remainder zero.
  always_comb begin
    is_div     = (op_q == OP_DIV) || (op_q == OP_DIVU);
    div_signed = (op_q == OP_DIV);
    a_neg      = div_signed && a_q[WIDTH-1];
    b_neg      = div_signed && b_q[WIDTH-1];
    b_is_zero  = (b_q == '0);
    a_mag      = a_neg ? -a_q : a_q;
    b_mag      = b_neg ? -b_q : b_q;
    b_safe     = b_is_zero ? WIDTH'(1) : b_mag;
    q_mag      = a_mag / b_safe;
    r_mag      = a_mag % b_safe;
    quot       = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem        = a_neg ? -r_mag : r_mag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      div_zero <= 1'b0;
      if (cancel) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else if (busy) begin
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          cnt  <= '0;
          if (is_div) begin
            if (b_is_zero) begin
              div_zero <= 1'b1;
            end else begin
              hi <= rem;
              lo <= quot;
            end
          end else begin
            hi <= mul_res[2*WIDTH-1:WIDTH];
            lo <= mul_res[WIDTH-1:0];
          end
        end else begin
          cnt <= cnt - CW'(1);
        end
      end else if (start) begin
        op_q <= op;
        a_q  <= rs_val;
        b_q  <= rt_val;
        busy <= 1'b1;
        cnt  <= ((op == OP_DIV) || (op == OP_DIVU)) ? CW'(DIV_LAT) : CW'(MULT_LAT);
      end else if (op_valid && op == OP_MTHI) begin
        hi <= rs_val;
      end else if (op_valid && op == OP_MTLO) begin
        lo <= rs_val;
      end
    end
  end

endmodule

// File: tb/tb_md_unit_param.sv
// Directed bench for md_unit_param: a 32-bit default instance plus a 16-bit
// instance with single-cycle multiply latency sharing the control inputs.
module tb_md_unit_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        cancel;
  logic        start32, busy32, dz32;
  logic [31:0] hi32, lo32;
  logic        start16, busy16, dz16;
  logic [15:0] hi16, lo16;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  md_unit_param dut32 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .cancel(cancel),
    .start(start32), .busy(busy32), .hi(hi32), .lo(lo32), .div_zero(dz32)
  );

  md_unit_param #(.WIDTH(16), .MULT_LAT(1), .DIV_LAT(10)) dut16 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .rs_val(rs_val[15:0]), .rt_val(rt_val[15:0]), .cancel(cancel),
    .start(start16), .busy(busy16), .hi(hi16), .lo(lo16), .div_zero(dz16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // driver: present one op for a single cycle, starting at a falling edge
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    op_valid = 1'b0; op = 4'd0;
  endtask

  // issue, measure busy length, compare result against the scoreboard head
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input bit use16, input bit exp_dz);
    int n = 0;
    bit dz_early = 0;
    logic [63:0] exp;
    logic [63:0] got;
    issue(o, a, b);
    while ((use16 ? busy16 : busy32) && n < 100) begin
      n++;
      if (dz32) dz_early = 1;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 64'(n), 64'(lat));
    exp = exp_q.pop_front();
    got = use16 ? {32'h0, hi16, lo16} : {hi32, lo32};
    check({tag, " hilo"}, got, exp);
    if (!use16) begin
      check({tag, " dz_during_busy"}, 64'(dz_early), 64'(0));
      check({tag, " dz_at_done"}, 64'(dz32), 64'(exp_dz));
      @(negedge clk);
      check({tag, " dz_after"}, 64'(dz32), 64'(0));
    end
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op = 4'd0; rs_val = '0; rt_val = '0; cancel = 1'b0;
    repeat (2) @(negedge clk);
    check("rst hi", 64'(hi32), 64'h0);
    check("rst lo", 64'(lo32), 64'h0);
    check("rst busy", 64'(busy32), 64'h0);
    check("rst dz", 64'(dz32), 64'h0);
    check("rst hilo16", {32'h0, hi16, lo16}, 64'h0);
    reset = 1'b0;

    exp_q.push_back(64'hFFFFFFFF_FFFFFFF1);
    run_op("mult -3*5", 4'd1, 32'hFFFFFFFD, 32'd5, 5, 0, 0);

    exp_q.push_back(64'h00000000_80000000);
    run_op("div min/-1", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 0, 0);
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
    run_op("div -7/2", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 0, 0);

    issue(4'd9, 32'h0, 32'h0);
    issue(4'd10, 32'hFFFFFFFF, 32'h0);
    check("mthi/mtlo", {hi32, lo32}, 64'h00000000_FFFFFFFF);
    check("mt busy", 64'(busy32), 64'h0);
    exp_q.push_back(64'h00000001_00000000);
    run_op("maddu 1*1", 4'd6, 32'd1, 32'd1, 5, 0, 0);
    exp_q.push_back(64'h00000000_FFFFFFFA);
    run_op("msub 2*3", 4'd7, 32'd2, 32'd3, 5, 0, 0);

    issue(4'd9, 32'h11, 32'h0);
    issue(4'd10, 32'h22, 32'h0);
    exp_q.push_back(64'h00000011_00000022);
    run_op("divu 7/0", 4'd4, 32'd7, 32'd0, 10, 0, 1);

    // div interrupted: mtlo while busy is dropped, cancel aborts without write
    issue(4'd3, 32'd100, 32'd7);
    @(negedge clk);
    op_valid = 1'b1; op = 4'd10; rs_val = 32'hDEAD;
    @(negedge clk);
    op_valid = 1'b0; op = 4'd0;
    @(negedge clk);
    @(negedge clk);
    check("cancel pre busy", 64'(busy32), 64'h1);
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel busy", 64'(busy32), 64'h0);
    repeat (6) begin
      @(negedge clk);
      if (busy32 || dz32) check("cancel quiet", {62'h0, busy32, dz32}, 64'h0);
    end
    check("cancel hilo", {hi32, lo32}, 64'h00000011_00000022);

    // cancel in the same cycle as an issue drops it; start stays combinational
    @(negedge clk);
    op_valid = 1'b1; op = 4'd11;
    #1 check("start op11", 64'(start32), 64'h0);
    op = 4'd1; rs_val = 32'd9; rt_val = 32'd9; cancel = 1'b1;
    #1 check("start w cancel", 64'(start32), 64'h1);
    @(negedge clk);
    op_valid = 1'b0; op = 4'd0; cancel = 1'b0;
    check("cancel issue busy", 64'(busy32), 64'h0);

    exp_q.push_back(64'h00000000_00000006);
    run_op("mult 2*3", 4'd1, 32'd2, 32'd3, 5, 0, 0);

    // asynchronous reset mid-operation, checked before any clock edge
    issue(4'd1, 32'd5, 32'd5);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async rst hi", 64'(hi32), 64'h0);
    check("async rst lo", 64'(lo32), 64'h0);
    check("async rst busy", 64'(busy32), 64'h0);
    check("async rst dz", 64'(dz32), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    exp_q.push_back(64'h00000000_00000010);
    run_op("w16 mult 4*4", 4'd1, 32'd4, 32'd4, 1, 1, 0);

    repeat (6) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
